gd_minimizer_param: RTL and testbench

GD_MINIMIZER_PARAM -- requirements
Module: gd_minimizer_param

---
 rtl/gd_pkg.sv | 26 ++
 rtl/fixed_val_comp.sv | 15 +
 rtl/gd_minimizer_param.sv | 193 +++++++++++++++++++
 tb/tb_gd_minimizer_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gd_pkg.sv
// Shared types and constants for the gradient-descent minimizer.
// Holds FSM state encodings, end-cause codes and arithmetic helper widths.
package gd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_FINISH = 3'd4
    } gd_state_e;

    typedef enum logic [1:0] {
        STS_MAX_ITER = 2'b00,
        STS_CONV     = 2'b01,
        STS_ABORT    = 2'b10,
        STS_SAT      = 2'b11
    } gd_status_e;

    // One guard bit on the x - step subtract exposes signed overflow.
    localparam int SUB_GUARD_W = 1;

    // |step| needs no extra bit: the most negative value clamps to max.
    localparam int ABS_GUARD_W = 0;

endpackage

// File: rtl/fixed_val_comp.sv
// Signed less-than compare of a candidate value against the running minimum.
// Kept separate so the value width can be swept without touching the FSM.
module fixed_val_comp
    import gd_pkg::*;
#(
    parameter int VAL_W = 64
) (
    input  logic signed [VAL_W-1:0] a,
    input  logic signed [VAL_W-1:0] b,
    output logic                    lt
);

    assign lt = (a < b);

endmodule

// File: rtl/gd_minimizer_param.sv
// Fixed-point gradient-descent minimizer driving an external evaluator.
// Tracks the lowest value seen and stops on saturation, convergence, limit or abort.
module gd_minimizer_param
    import gd_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 8,
    parameter int VAL_W    = 64,
    parameter int MAX_ITER = 16,
    parameter int STOP_EPS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DATA_W-1:0]             x_init,
    output logic                          ev_start,
    output logic [DATA_W-1:0]             ev_x,
    input  logic                          ev_done,
    input  logic [VAL_W-1:0]              ev_value,
    input  logic [DATA_W-1:0]             ev_step,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             x_at_min,
    output logic [VAL_W-1:0]              y_min,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_used,
    output logic [1:0]                    status
);

    localparam int IT_W  = $clog2(MAX_ITER + 1);
    localparam int SUB_W = DATA_W + SUB_GUARD_W;
    localparam int ABS_W = DATA_W + ABS_GUARD_W;

    localparam logic [DATA_W-1:0] X_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] X_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [VAL_W-1:0]  VAL_MAX = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic [ABS_W-1:0]  EPS     = ABS_W'(STOP_EPS);
    localparam logic [IT_W-1:0]   IT_LAST = IT_W'(MAX_ITER);

    // FRAC_W only sets the binary point; the arithmetic is scale-free.
    localparam int UNUSED_FRAC = FRAC_W;

    gd_state_e          state;
    gd_state_e          state_nxt;
    logic [1:0]         status_nxt;
    logic [DATA_W-1:0]  x_reg;
    logic [VAL_W-1:0]   val_q;
    logic [DATA_W-1:0]  step_q;

    logic [SUB_W-1:0]   diff;
    logic               ovf;
    logic [DATA_W-1:0]  x_next;
    logic [ABS_W-1:0]   step_abs;
    logic               converged;
    logic               last_iter;
    logic               val_lt;

    // Saturating x - step using a sign-extended guard bit.
    always_comb begin
        diff   = {x_reg[DATA_W-1], x_reg} - {step_q[DATA_W-1], step_q};
        ovf    = diff[SUB_W-1] ^ diff[DATA_W-1];
        x_next = diff[DATA_W-1:0];
        if (ovf) begin
            x_next = diff[SUB_W-1] ? X_MIN : X_MAX;
        end
    end

    // |step| with the most negative value clamped to the positive maximum.
    always_comb begin
        step_abs = step_q;
        if (step_q[DATA_W-1]) begin
            step_abs = (step_q == X_MIN) ? X_MAX : (~step_q + 1'b1);
        end
        converged = (step_abs <= EPS);
        last_iter = ((iter_used + IT_W'(1)) == IT_LAST);
    end

    fixed_val_comp #(
        .VAL_W (VAL_W)
    ) u_comp (
        .a  (val_q),
        .b  (y_min),
        .lt (val_lt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and end-cause selection.
    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_nxt  = ST_FINISH;
                    status_nxt = STS_ABORT;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_nxt  = ST_FINISH;
                    status_nxt = STS_ABORT;
                end else if (ev_done) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_nxt = ST_FINISH;
                if (abort) begin
                    status_nxt = STS_ABORT;
                end else if (ovf) begin
                    status_nxt = STS_SAT;
                end else if (converged) begin
                    status_nxt = STS_CONV;
                end else if (last_iter) begin
                    status_nxt = STS_MAX_ITER;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Search datapath: load on start, latch results, fold into the minimum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            val_q     <= '0;
            step_q    <= '0;
            x_at_min  <= '0;
            y_min     <= VAL_MAX;
            iter_used <= '0;
            status    <= STS_MAX_ITER;
        end else begin
            status <= status_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_reg     <= x_init;
                        x_at_min  <= x_init;
                        y_min     <= VAL_MAX;
                        iter_used <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ev_done && !abort) begin
                        val_q  <= ev_value;
                        step_q <= ev_step;
                    end
                end
                ST_UPDATE: begin
                    if (!abort) begin
                        iter_used <= iter_used + IT_W'(1);
                        x_reg     <= x_next;
                        if (val_lt) begin
                            y_min    <= val_q;
                            x_at_min <= x_reg;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ev_start = (state == ST_ISSUE);
    assign ev_x     = x_reg;
    assign busy     = (state == ST_ISSUE) || (state == ST_WAIT) ||
                      (state == ST_UPDATE);
    assign done     = (state == ST_FINISH);

endmodule

// File: tb/tb_gd_minimizer_param.sv
// Directed bench for gd_minimizer_param with the bench acting as evaluator.
// Two instances: default MAX_ITER=16 and MAX_ITER=3.
module tb_gd_minimizer_param;

    localparam logic [63:0] VMAX = 64'h7FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0;
    logic        start3;
    logic        abort;
    logic [31:0] x_init;
    logic        ev_done;
    logic [63:0] ev_value;
    logic [31:0] ev_step;

    logic        ev_start0;
    logic [31:0] ev_x0;
    logic        busy0;
    logic        done0;
    logic [31:0] x_at_min0;
    logic [63:0] y_min0;
    logic [4:0]  iter0;
    logic [1:0]  status0;

    logic        ev_start3;
    logic [31:0] ev_x3;
    logic        busy3;
    logic        done3;
    logic [31:0] x_at_min3;
    logic [63:0] y_min3;
    logic [1:0]  iter3;
    logic [1:0]  status3;

    int n_tests = 0;
    int n_fail  = 0;
    int nev3    = 0;
    int ndone0  = 0;
    int snap;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ev_start3) nev3++;
        if (done0) ndone0++;
    end

    gd_minimizer_param u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .abort     (abort),
        .x_init    (x_init),
        .ev_start  (ev_start0),
        .ev_x      (ev_x0),
        .ev_done   (ev_done),
        .ev_value  (ev_value),
        .ev_step   (ev_step),
        .busy      (busy0),
        .done      (done0),
        .x_at_min  (x_at_min0),
        .y_min     (y_min0),
        .iter_used (iter0),
        .status    (status0)
    );

    gd_minimizer_param #(
        .MAX_ITER (3)
    ) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .abort     (abort),
        .x_init    (x_init),
        .ev_start  (ev_start3),
        .ev_x      (ev_x3),
        .ev_done   (ev_done),
        .ev_value  (ev_value),
        .ev_step   (ev_step),
        .busy      (busy3),
        .done      (done3),
        .x_at_min  (x_at_min3),
        .y_min     (y_min3),
        .iter_used (iter3),
        .status    (status3)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the ISSUE cycle; returns in the cycle after ev_done.
    task automatic respond(input logic [63:0] v, input logic [31:0] s,
                           input logic ab);
        @(negedge clk);
        ev_done  = 1'b1;
        ev_value = v;
        ev_step  = s;
        abort    = ab;
        @(negedge clk);
        ev_done  = 1'b0;
        abort    = 1'b0;
    endtask

    // f=(x-5)^2, step = x-5 in Q8; converges on the second evaluation.
    task automatic clean_run(input string tag);
        x_init = 32'h0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk({tag, "_evs0"}, ev_start0, 1);
        chk({tag, "_x0"}, ev_x0, 0);
        chk({tag, "_busy"}, busy0, 1);
        respond(64'h19_0000, 32'hFFFF_FB00, 1'b0);
        chk({tag, "_upd_noevs"}, ev_start0, 0);
        @(negedge clk);
        chk({tag, "_evs1"}, ev_start0, 1);
        chk({tag, "_x1"}, ev_x0, 32'h500);
        respond(64'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk({tag, "_done"}, done0, 1);
        chk({tag, "_busy_lo"}, busy0, 0);
        chk({tag, "_status"}, status0, 2'b01);
        chk({tag, "_xmin"}, x_at_min0, 32'h500);
        chk({tag, "_ymin"}, y_min0, 0);
        chk({tag, "_iter"}, iter0, 2);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done0, 0);
        chk({tag, "_hold"}, x_at_min0, 32'h500);
    endtask

    initial begin
        rst_n    = 1'b0;
        start0   = 1'b0;
        start3   = 1'b0;
        abort    = 1'b0;
        x_init   = '0;
        ev_done  = 1'b0;
        ev_value = '0;
        ev_step  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_evs", ev_start0, 0);
        chk("rst_ymin", y_min0, VMAX);
        chk("rst_xmin", x_at_min0, 0);
        chk("rst_iter", iter0, 0);
        chk("rst_status", status0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_noevs", ev_start0, 0);

        clean_run("conv");

        // MAX_ITER=3, step 1.0, last value ties the second
        snap   = nev3;
        x_init = 32'h100;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("mi_x0", ev_x3, 32'h100);
        respond(64'd30, 32'h100, 1'b0);
        @(negedge clk);
        chk("mi_x1", ev_x3, 32'h0);
        respond(64'd20, 32'h100, 1'b0);
        @(negedge clk);
        chk("mi_x2", ev_x3, 32'hFFFF_FF00);
        respond(64'd20, 32'h100, 1'b0);
        @(negedge clk);
        chk("mi_done", done3, 1);
        chk("mi_status", status3, 2'b00);
        chk("mi_iter", iter3, 3);
        chk("mi_ymin", y_min3, 20);
        chk("mi_tie_xmin", x_at_min3, 32'h0);
        chk("mi_nevs", 64'(nev3 - snap), 3);

        // saturation
        x_init = 32'h7FFF_FF00;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("sat_x0", ev_x0, 32'h7FFF_FF00);
        respond(64'd100, 32'hFFFF_FE00, 1'b0);
        @(negedge clk);
        chk("sat_done", done0, 1);
        chk("sat_status", status0, 2'b11);
        chk("sat_iter", iter0, 1);
        chk("sat_ymin", y_min0, 100);
        chk("sat_xmin", x_at_min0, 32'h7FFF_FF00);
        @(negedge clk);
        chk("sat_noevs", ev_start0, 0);

        // abort on the second ev_done
        snap   = ndone0;
        x_init = 32'h0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        respond(64'd50, 32'hFFFF_FF00, 1'b0);
        @(negedge clk);
        chk("ab_x1", ev_x0, 32'h100);
        respond(64'd10, 32'h0, 1'b1);
        chk("ab_done", done0, 1);
        chk("ab_status", status0, 2'b10);
        chk("ab_iter", iter0, 1);
        chk("ab_ymin", y_min0, 50);
        chk("ab_xmin", x_at_min0, 0);
        repeat (3) @(negedge clk);
        chk("ab_done_once", 64'(ndone0 - snap), 1);

        // asynchronous reset while waiting on the evaluator
        x_init = 32'h300;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        chk("mr_busy_wait", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy0, 0);
        chk("mr_ymin", y_min0, VMAX);
        chk("mr_xmin", x_at_min0, 0);
        chk("mr_iter", iter0, 0);
        chk("mr_status", status0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_noevs", ev_start0, 0);
        clean_run("rerun");

        // start held high across the whole search and FINISH
        x_init = 32'h0;
        start0 = 1'b1;
        @(negedge clk);
        chk("hold_evs0", ev_start0, 1);
        x_init = 32'h700;
        respond(64'd5, 32'h0, 1'b0);
        @(negedge clk);
        chk("hold_done", done0, 1);
        chk("hold_xmin", x_at_min0, 0);
        chk("hold_status", status0, 2'b01);
        chk("hold_iter", iter0, 1);
        @(negedge clk);
        chk("hold_idle_busy", busy0, 0);
        chk("hold_idle_evs", ev_start0, 0);
        @(negedge clk);
        start0 = 1'b0;
        chk("hold_evs1", ev_start0, 1);
        chk("hold_x_new", ev_x0, 32'h700);
        respond(64'd7, 32'h0, 1'b0);
        @(negedge clk);
        chk("hold_done2", done0, 1);
        chk("hold_xmin2", x_at_min0, 32'h700);
        chk("hold_ymin2", y_min0, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
